multicycle_ctrl: RTL and testbench

//  Control FSM that sequences the shared RV32I datapath (PC register, instr mem, reg_file, alu,

---
 rtl/mc_ctrl_pkg.sv | 82 ++++++++
 rtl/mc_opcode_deco.sv | 50 +++++
 rtl/multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared types and encodings for the multicycle RV32I control FSM.
//   state_t        : controller states
//   instr_class_t  : instruction class produced by the opcode decoder
//   ctrl_t         : bundle of every datapath enable / mux select the
//                    controller drives, so it can be cleared as one unit
//   OP_*           : supported major opcodes (instr[6:0])
//   IF_SEL_*       : if_mux select encodings (next PC source)
//   WB_SEL_*       : wb_mux select encodings (register write-back source)
//   SIZE_*         : funct3[1:0] data access size encodings
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_LD,
        CLS_ST,
        CLS_BR,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_NONE
    } instr_class_t;

    typedef struct packed {
        logic       instRd;
        logic       irWr;
        logic       pcWr;
        logic [1:0] ifSel;
        logic       exSel;
        logic [1:0] wbSel;
        logic       rfRd;
        logic       rfWr;
        logic       memRead;
        logic       memWrite;
        logic       oneByte;
        logic       twoBytes;
        logic       fourBytes;
    } ctrl_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] IF_SEL_PC4   = 2'b00;
    localparam logic [1:0] IF_SEL_PCIMM = 2'b01;
    localparam logic [1:0] IF_SEL_ALU   = 2'b10;

    localparam logic [1:0] WB_SEL_ALU   = 2'b00;
    localparam logic [1:0] WB_SEL_MEM   = 2'b01;
    localparam logic [1:0] WB_SEL_PC4   = 2'b10;
    localparam logic [1:0] WB_SEL_PCIMM = 2'b11;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Only register-register ALU ops and branches feed rs2 into the ALU;
    // everything else takes the immediate as the second operand.
    function automatic logic usesImmediate(input instr_class_t cls);
        return !((cls == CLS_R) || (cls == CLS_BR));
    endfunction

endpackage

// File: rtl/mc_opcode_deco.sv
// ---------------------------------------------------------------------------
// mc_opcode_deco
// Purely combinational decoder: maps the major opcode to an instruction
// class and flags whether the controller can execute it.
// Ports:
//   opcode_i  in  7   instr[6:0]
//   size_i    in  2   instr[13:12] (funct3[1:0]), needed to reject the
//                     unsupported 64-bit load/store width
//   class_o   out     decoded instruction class (CLS_NONE if unknown)
//   legal_o   out 1   1 when the instruction is supported
// ---------------------------------------------------------------------------
module mc_opcode_deco
    import mc_ctrl_pkg::*;
(
    input  logic [6:0]   opcode_i,
    input  logic [1:0]   size_i,
    output instr_class_t class_o,
    output logic         legal_o
);

    // Classify the opcode. Loads and stores with funct3[1:0]=11 would be a
    // doubleword access, which this RV32 datapath cannot perform, so they
    // are reported as illegal here and the FSM traps on them at DECODE.
    always_comb begin
        class_o = CLS_NONE;
        legal_o = 1'b1;
        case (opcode_i)
            OP_R:     class_o = CLS_R;
            OP_I:     class_o = CLS_I;
            OP_LD: begin
                class_o = CLS_LD;
                legal_o = (size_i != 2'b11);
            end
            OP_ST: begin
                class_o = CLS_ST;
                legal_o = (size_i != 2'b11);
            end
            OP_BR:    class_o = CLS_BR;
            OP_JAL:   class_o = CLS_JAL;
            OP_JALR:  class_o = CLS_JALR;
            OP_LUI:   class_o = CLS_LUI;
            OP_AUIPC: class_o = CLS_AUIPC;
            default: begin
                class_o = CLS_NONE;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM that sequences the shared RV32I datapath over several cycles
// per instruction (FETCH, DECODE, EXECUTE, MEM, WB, TRAP). Drives every
// datapath enable and mux select, handshakes with the instruction and data
// memories, flags unsupported opcodes and counts retired instructions.
// Ports:
//   clk_i         in   1          clock, rising edge
//   rst_ni        in   1          asynchronous active-low reset
//   instr_i       in   INST_SIZE  instruction register contents
//   comparison_i  in   1          ALU branch result (1 = taken)
//   inst_ready_i  in   1          instruction memory data valid
//   mem_ready_i   in   1          data memory access complete
//   inst_rd_o     out  1          instruction memory read request
//   ir_wr_o       out  1          load instruction register
//   pc_wr_o       out  1          update PC from if_mux
//   if_mux_sel_o  out  2          next PC source (IF_SEL_*)
//   ex_mux_sel_o  out  1          ALU operand B: 0 rs2, 1 immediate
//   wb_mux_sel_o  out  2          write-back source (WB_SEL_*)
//   reg_file_rd_o out  1          register file read enable
//   reg_file_wr_o out  1          register file write enable
//   mem_read_o    out  1          data memory read request
//   mem_write_o   out  1          data memory write request
//   one_byte_o    out  1          byte access
//   two_bytes_o   out  1          halfword access
//   four_bytes_o  out  1          word access
//   illegal_o     out  1          sticky unsupported-opcode flag
//   instret_o     out  CNT_WIDTH  retired instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int INST_SIZE = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [INST_SIZE-1:0] instr_i,
    input  logic                 comparison_i,
    input  logic                 inst_ready_i,
    input  logic                 mem_ready_i,
    output logic                 inst_rd_o,
    output logic                 ir_wr_o,
    output logic                 pc_wr_o,
    output logic [1:0]           if_mux_sel_o,
    output logic                 ex_mux_sel_o,
    output logic [1:0]           wb_mux_sel_o,
    output logic                 reg_file_rd_o,
    output logic                 reg_file_wr_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic                 one_byte_o,
    output logic                 two_bytes_o,
    output logic                 four_bytes_o,
    output logic                 illegal_o,
    output logic [CNT_WIDTH-1:0] instret_o
);

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_WIDTH-1:0]   instret_q;
    logic [CNT_WIDTH-1:0]   instret_d;
    logic                   illegal_q;
    logic                   illegal_d;

    instr_class_t           instrClass;
    logic                   opLegal;
    logic [1:0]             accessSize;
    ctrl_t                  ctrlRaw;
    ctrl_t                  ctrlOut;
    logic                   retire;
    logic                   unusedInstrBits;

    assign accessSize = instr_i[13:12];

    // Register fields, funct3[2] (sign/unsigned load variant) and the
    // immediate are consumed by the datapath, not by the controller.
    assign unusedInstrBits = ^{instr_i[INST_SIZE-1:14], instr_i[11:7]};

    mc_opcode_deco u_deco (
        .opcode_i (instr_i[6:0]),
        .size_i   (accessSize),
        .class_o  (instrClass),
        .legal_o  (opLegal)
    );

    // State register. Reset always lands in FETCH so the core restarts
    // cleanly even if it was interrupted in the middle of a memory access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The ready inputs only matter in the state that is
    // waiting on them; a stray ready pulse elsewhere has no effect. TRAP
    // only exits through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (inst_ready_i) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = opLegal ? ST_EXECUTE : ST_TRAP;
            end
            ST_EXECUTE: begin
                if (instrClass == CLS_BR) begin
                    state_d = ST_FETCH;
                end else if ((instrClass == CLS_LD) || (instrClass == CLS_ST)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ready_i) begin
                    state_d = (instrClass == CLS_LD) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

    // Output decode. Mostly Moore; ir_wr, the store's pc_wr and the branch
    // target select additionally look at the handshake / comparison inputs
    // so no extra cycle is spent per instruction.
    always_comb begin
        ctrlRaw = '0;
        case (state_q)
            ST_FETCH: begin
                ctrlRaw.instRd = 1'b1;
                ctrlRaw.irWr   = inst_ready_i;
            end
            ST_DECODE: begin
                ctrlRaw.rfRd = 1'b1;
            end
            ST_EXECUTE: begin
                ctrlRaw.rfRd  = 1'b1;
                ctrlRaw.exSel = usesImmediate(instrClass);
                if (instrClass == CLS_BR) begin
                    ctrlRaw.pcWr  = 1'b1;
                    ctrlRaw.ifSel = comparison_i ? IF_SEL_PCIMM : IF_SEL_PC4;
                end
            end
            ST_MEM: begin
                ctrlRaw.exSel     = 1'b1;
                ctrlRaw.oneByte   = (accessSize == SIZE_BYTE);
                ctrlRaw.twoBytes  = (accessSize == SIZE_HALF);
                ctrlRaw.fourBytes = (accessSize == SIZE_WORD);
                ctrlRaw.memRead   = (instrClass == CLS_LD);
                ctrlRaw.memWrite  = (instrClass == CLS_ST);
                if ((instrClass == CLS_ST) && mem_ready_i) begin
                    ctrlRaw.pcWr  = 1'b1;
                    ctrlRaw.ifSel = IF_SEL_PC4;
                end
            end
            ST_WB: begin
                ctrlRaw.rfWr = 1'b1;
                ctrlRaw.pcWr = 1'b1;
                case (instrClass)
                    CLS_LD:             ctrlRaw.wbSel = WB_SEL_MEM;
                    CLS_JAL, CLS_JALR:  ctrlRaw.wbSel = WB_SEL_PC4;
                    CLS_AUIPC:          ctrlRaw.wbSel = WB_SEL_PCIMM;
                    default:            ctrlRaw.wbSel = WB_SEL_ALU;
                endcase
                case (instrClass)
                    CLS_JAL:  ctrlRaw.ifSel = IF_SEL_PCIMM;
                    CLS_JALR: ctrlRaw.ifSel = IF_SEL_ALU;
                    default:  ctrlRaw.ifSel = IF_SEL_PC4;
                endcase
            end
            default: begin
                ctrlRaw = '0;
            end
        endcase
    end

    // While reset is held every output must read zero straight away, even
    // though the state register already sits in FETCH (which would request
    // an instruction). The masking is kept off the internal retire path so
    // reset never reaches a flop data input.
    assign ctrlOut = rst_ni ? ctrlRaw : '0;
    assign retire  = ctrlRaw.pcWr;

    // Every instruction retires in exactly the cycle it writes the PC, so
    // the PC write strobe doubles as the retire event. The counter wraps.
    assign instret_d = instret_q + CNT_WIDTH'(retire);
    assign illegal_d = illegal_q | ((state_q == ST_DECODE) && !opLegal);

    // Retire counter and sticky illegal flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    assign inst_rd_o     = ctrlOut.instRd;
    assign ir_wr_o       = ctrlOut.irWr;
    assign pc_wr_o       = ctrlOut.pcWr;
    assign if_mux_sel_o  = ctrlOut.ifSel;
    assign ex_mux_sel_o  = ctrlOut.exSel;
    assign wb_mux_sel_o  = ctrlOut.wbSel;
    assign reg_file_rd_o = ctrlOut.rfRd;
    assign reg_file_wr_o = ctrlOut.rfWr;
    assign mem_read_o    = ctrlOut.memRead;
    assign mem_write_o   = ctrlOut.memWrite;
    assign one_byte_o    = ctrlOut.oneByte;
    assign two_bytes_o   = ctrlOut.twoBytes;
    assign four_bytes_o  = ctrlOut.fourBytes;
    assign illegal_o     = illegal_q;
    assign instret_o     = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. A table of instructions with
// their expected cycle counts and control outputs is run back to back; the
// expected retire-cycle outputs are queued when an instruction is issued and
// popped when the DUT raises pc_wr. Hand-written sequences cover trapping,
// reset out of TRAP and reset in the middle of a data memory access.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [31:0] instr_i;
    logic        comparison_i;
    logic        inst_ready_i;
    logic        mem_ready_i;
    logic        inst_rd_o;
    logic        ir_wr_o;
    logic        pc_wr_o;
    logic [1:0]  if_mux_sel_o;
    logic        ex_mux_sel_o;
    logic [1:0]  wb_mux_sel_o;
    logic        reg_file_rd_o;
    logic        reg_file_wr_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        one_byte_o;
    logic        two_bytes_o;
    logic        four_bytes_o;
    logic        illegal_o;
    logic [31:0] instret_o;

    // One instruction and everything the bench expects to see while it runs.
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        comp;
        int          instWait;
        int          memWait;
        int          cycles;
        int          memCycles;
        logic [1:0]  ifSel;
        logic [1:0]  wbSel;
        logic        regWr;
        logic        memRd;
        logic        memWr;
        logic [2:0]  size;
        logic        exSel;
    } vec_t;

    // Expected outputs in the cycle the instruction retires.
    typedef struct {
        logic [1:0]  ifSel;
        logic [1:0]  wbSel;
        logic        regWr;
        logic [31:0] instretBefore;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sbQueue[$];
    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [31:0] expInstret  = 0;

    multicycle_ctrl #(
        .INST_SIZE (32),
        .CNT_WIDTH (32)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .instr_i       (instr_i),
        .comparison_i  (comparison_i),
        .inst_ready_i  (inst_ready_i),
        .mem_ready_i   (mem_ready_i),
        .inst_rd_o     (inst_rd_o),
        .ir_wr_o       (ir_wr_o),
        .pc_wr_o       (pc_wr_o),
        .if_mux_sel_o  (if_mux_sel_o),
        .ex_mux_sel_o  (ex_mux_sel_o),
        .wb_mux_sel_o  (wb_mux_sel_o),
        .reg_file_rd_o (reg_file_rd_o),
        .reg_file_wr_o (reg_file_wr_o),
        .mem_read_o    (mem_read_o),
        .mem_write_o   (mem_write_o),
        .one_byte_o    (one_byte_o),
        .two_bytes_o   (two_bytes_o),
        .four_bytes_o  (four_bytes_o),
        .illegal_o     (illegal_o),
        .instret_o     (instret_o)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Last-resort guard so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Every datapath enable / select, without illegal and instret.
    function automatic logic [14:0] ctrlBits();
        return {inst_rd_o, ir_wr_o, pc_wr_o, if_mux_sel_o, ex_mux_sel_o,
                wb_mux_sel_o, reg_file_rd_o, reg_file_wr_o, mem_read_o,
                mem_write_o, one_byte_o, two_bytes_o, four_bytes_o};
    endfunction

    function automatic logic [47:0] allOutputs();
        return {ctrlBits(), illegal_o, instret_o};
    endfunction

    // Drive all DUT inputs for the coming cycle.
    task automatic applyStimulus(input logic [31:0] instr, input logic comp,
                                 input logic instReady, input logic memReady);
        instr_i      = instr;
        comparison_i = comp;
        inst_ready_i = instReady;
        mem_ready_i  = memReady;
    endtask

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Compare the retire cycle against the oldest queued expectation.
    task automatic popAndCompare(input string name);
        sb_t exp;
        if (sbQueue.size() == 0) begin
            checkOutput({name, ":sbUnderflow"}, 64'd1, 64'd0);
        end else begin
            exp = sbQueue.pop_front();
            checkOutput({name, ":ifSel"}, 64'(if_mux_sel_o), 64'(exp.ifSel));
            checkOutput({name, ":regWr"}, 64'(reg_file_wr_o), 64'(exp.regWr));
            checkOutput({name, ":instret"}, 64'(instret_o), 64'(exp.instretBefore));
            if (exp.regWr) begin
                checkOutput({name, ":wbSel"}, 64'(wb_mux_sel_o), 64'(exp.wbSel));
            end
        end
    endtask

    // Run one instruction from FETCH to retirement. The memories answer
    // after instWait / memWait request cycles; outside those waits the ready
    // lines are left high so stray readies are exercised too.
    task automatic runInstr(input vec_t v);
        int         cyc       = 0;
        int         rdPulses  = 0;
        int         memPulses = 0;
        int         rfRdCount = 0;
        int         rfWrCount = 0;
        logic       sawMemRd  = 1'b0;
        logic       sawMemWr  = 1'b0;
        logic       sawEx     = 1'b0;
        logic [2:0] sizeSeen  = 3'b000;
        logic       retired   = 1'b0;
        sbQueue.push_back('{v.ifSel, v.wbSel, v.regWr, expInstret});
        expInstret++;
        while (!retired && (cyc < 60)) begin
            applyStimulus(v.instr, v.comp, rdPulses >= v.instWait, memPulses >= v.memWait);
            @(negedge clk);
            cyc++;
            if (inst_rd_o) rdPulses++;
            if (mem_read_o || mem_write_o) memPulses++;
            if (reg_file_rd_o) rfRdCount++;
            if (reg_file_wr_o) rfWrCount++;
            sawMemRd |= mem_read_o;
            sawMemWr |= mem_write_o;
            sawEx    |= ex_mux_sel_o;
            sizeSeen |= {four_bytes_o, two_bytes_o, one_byte_o};
            if (pc_wr_o) begin
                popAndCompare(v.name);
                retired = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!retired) begin
            checkOutput({v.name, ":retireTimeout"}, 64'd0, 64'd1);
            void'(sbQueue.pop_back());
            expInstret--;
        end
        checkOutput({v.name, ":cycles"}, 64'(cyc), 64'(v.cycles));
        checkOutput({v.name, ":memCycles"}, 64'(memPulses), 64'(v.memCycles));
        checkOutput({v.name, ":rfRdCycles"}, 64'(rfRdCount), 64'd2);
        checkOutput({v.name, ":rfWrCycles"}, 64'(rfWrCount), 64'(v.regWr));
        checkOutput({v.name, ":memRead"}, 64'(sawMemRd), 64'(v.memRd));
        checkOutput({v.name, ":memWrite"}, 64'(sawMemWr), 64'(v.memWr));
        checkOutput({v.name, ":size"}, 64'(sizeSeen), 64'(v.size));
        checkOutput({v.name, ":exSel"}, 64'(sawEx), 64'(v.exSel));
    endtask

    // Unsupported instruction: trap after DECODE, stay there with no
    // enables for ten cycles, then recover through reset.
    task automatic runTrap(input string name, input logic [31:0] instr);
        int badCycles = 0;
        applyStimulus(instr, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput({name, ":fetchIrWr"}, 64'(ir_wr_o), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput({name, ":decodeIllegal"}, 64'(illegal_o), 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((illegal_o !== 1'b1) || (ctrlBits() !== 15'd0) || (instret_o !== expInstret)) begin
                badCycles++;
            end
            @(posedge clk);
            #1;
        end
        checkOutput({name, ":trapHoldBadCycles"}, 64'(badCycles), 64'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput({name, ":resetOutputs"}, 64'(allOutputs()), 64'd0);
        expInstret = 0;
        inst_ready_i = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(negedge clk);
        checkOutput({name, ":recoverFetch"}, 64'(inst_rd_o), 64'd1);
        checkOutput({name, ":recoverIllegal"}, 64'(illegal_o), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {name, instr, comp, instWait, memWait, cycles, memCycles,
        //  ifSel, wbSel, regWr, memRd, memWr, size{4,2,1}, exSel}
        vecs.push_back('{"ADDI",     32'h00500093, 1'b0, 0, 0, 4, 0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1});
        vecs.push_back('{"LW_wait3", 32'h0000A103, 1'b0, 0, 3, 8, 4, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 3'b100, 1'b1});
        vecs.push_back('{"SW",       32'h0020A223, 1'b0, 0, 0, 4, 1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 3'b100, 1'b1});
        vecs.push_back('{"BEQ_taken",32'h00000463, 1'b1, 0, 0, 3, 0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0});
        vecs.push_back('{"BEQ_not",  32'h00000463, 1'b0, 0, 0, 3, 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0});
        vecs.push_back('{"JAL",      32'h008000EF, 1'b0, 0, 0, 4, 0, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1});
        vecs.push_back('{"JALR",     32'h000080E7, 1'b0, 0, 0, 4, 0, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1});
        vecs.push_back('{"LUI",      32'h123450B7, 1'b0, 0, 0, 4, 0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1});
        vecs.push_back('{"AUIPC",    32'h00001097, 1'b0, 0, 0, 4, 0, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1});
        vecs.push_back('{"ADD",      32'h002081B3, 1'b1, 0, 0, 4, 0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0});
        vecs.push_back('{"LB",       32'h00008183, 1'b0, 0, 0, 5, 1, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 3'b001, 1'b1});
        vecs.push_back('{"SH_wait2", 32'h00209023, 1'b0, 0, 2, 6, 3, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1});
        vecs.push_back('{"ADDI_slowFetch", 32'h00500093, 1'b0, 2, 0, 6, 0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1});

        // Reset state: everything zero even with inst_ready high.
        rst_ni = 1'b0;
        applyStimulus(32'h00000000, 1'b0, 1'b1, 1'b1);
        #12;
        checkOutput("resetOutputs", 64'(allOutputs()), 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            runInstr(vecs[i]);
        end
        checkOutput("instretAfterTable", 64'(instret_o), 64'(expInstret));
        checkOutput("scoreboardDrained", 64'(sbQueue.size()), 64'd0);

        runTrap("trapAllOnes", 32'hFFFFFFFF);
        runTrap("trapLoadDouble", 32'h0000B103);

        // Reset while a load is stalled in MEM with mem_read asserted.
        runInstr(vecs[0]);
        begin
            logic seen = 1'b0;
            applyStimulus(32'h0000A103, 1'b0, 1'b1, 1'b0);
            for (int i = 0; (i < 10) && !seen; i++) begin
                @(negedge clk);
                if (mem_read_o) seen = 1'b1;
                @(posedge clk);
                #1;
            end
            checkOutput("midMemReached", 64'(seen), 64'd1);
        end
        @(negedge clk);
        checkOutput("midMemReadHeld", 64'(mem_read_o), 64'd1);
        checkOutput("midMemInstret", 64'(instret_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("midMemResetOutputs", 64'(allOutputs()), 64'd0);
        inst_ready_i = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(negedge clk);
        checkOutput("midMemRecoverFetch", 64'(ctrlBits()), 64'(15'b100000000000000));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
